// File: rtl/spi_sram_pkg.sv
// Shared SPI/SQI serial-SRAM definitions: default opcodes, pad width and target FSM encoding.
package spi_sram_pkg;

  localparam int unsigned SIO_W = 4;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam logic [7:0] SPI_CMD_EQIO  = 8'h38;
  localparam logic [7:0] SPI_CMD_RSTIO = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_RDATA = 3'd4,
    ST_WDATA = 3'd5,
    ST_DRAIN = 3'd6
  } spi_tgt_state_e;

  // Index of the final sample edge of a byte: 8 bits in SPI mode, 2 nibbles in quad mode.
  function automatic logic [2:0] last_bit_idx(input logic quad);
    return quad ? 3'd1 : 3'd7;
  endfunction

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizers for cs/sck/sio plus sck rise/fall and cs fall/rise pulses.
module spi_target_sync
  import spi_sram_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_i,
  input  logic             sck_i,
  input  logic [SIO_W-1:0] sio_i,
  output logic             cs_o,
  output logic [SIO_W-1:0] sio_o,
  output logic             sck_rise_c,
  output logic             sck_fall_c,
  output logic             cs_fall_c,
  output logic             cs_rise_c
);

  // Bit 0 is the metastability stage, bit 1 the synchronized level, bit 2 its previous value.
  logic [2:0]       cs_q;
  logic [2:0]       sck_q;
  logic [SIO_W-1:0] sio_q1;
  logic [SIO_W-1:0] sio_q2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q   <= 3'b111;
      sck_q  <= 3'b000;
      sio_q1 <= '0;
      sio_q2 <= '0;
    end else begin
      cs_q   <= {cs_q[1:0], cs_i};
      sck_q  <= {sck_q[1:0], sck_i};
      sio_q1 <= sio_i;
      sio_q2 <= sio_q1;
    end
  end

  assign cs_o       = cs_q[1];
  assign sio_o      = sio_q2;
  assign sck_rise_c = sck_q[1] & ~sck_q[2];
  assign sck_fall_c = ~sck_q[1] & sck_q[2];
  assign cs_fall_c  = ~cs_q[1] & cs_q[2];
  assign cs_rise_c  = cs_q[1] & ~cs_q[2];

endmodule

// File: rtl/spi_sram_target.sv
// SPI/SQI serial-SRAM responder with an internal byte array.
// Define SPI_SRAM_TARGET_BACKDOOR_EN to add the bd_addr/bd_rdata second read port.
module spi_sram_target
  import spi_sram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 65536,
  parameter int unsigned ADDR_BYTES  = 2,
  parameter int unsigned DUMMY_BYTES = 1,
  parameter logic [7:0]  CMD_READ    = SPI_CMD_READ,
  parameter logic [7:0]  CMD_WRITE   = SPI_CMD_WRITE,
  parameter logic [7:0]  CMD_EQIO    = SPI_CMD_EQIO,
  parameter logic [7:0]  CMD_RSTIO   = SPI_CMD_RSTIO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_pin,
  input  logic             sck_pin,
  input  logic [SIO_W-1:0] sio_in,
  output logic [SIO_W-1:0] sio_out,
  output logic [SIO_W-1:0] sio_oe,
  output logic             quad_mode,
  output logic             busy,
  output logic             cmd_err
`ifdef SPI_SRAM_TARGET_BACKDOOR_EN
  ,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_addr,
  output logic [7:0]                   bd_rdata
`endif
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = 4;

  logic             cs_sync;
  logic [SIO_W-1:0] sio_sync;
  logic             sck_rise_c;
  logic             sck_fall_c;
  logic             cs_fall_c;
  logic             cs_rise_c;

  spi_target_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_i       (cs_pin),
    .sck_i      (sck_pin),
    .sio_i      (sio_in),
    .cs_o       (cs_sync),
    .sio_o      (sio_sync),
    .sck_rise_c (sck_rise_c),
    .sck_fall_c (sck_fall_c),
    .cs_fall_c  (cs_fall_c),
    .cs_rise_c  (cs_rise_c)
  );

  spi_tgt_state_e   state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             is_read_q, is_read_d;
  logic             quad_q, quad_d;
  logic [SIO_W-1:0] sio_out_q, sio_out_d;
  logic [SIO_W-1:0] sio_oe_q, sio_oe_d;
  logic             cmd_err_q, cmd_err_d;
  logic             busy_q, busy_d;

  logic [7:0]       mem [MEM_DEPTH];
  logic [7:0]       rdata_q;
  logic             mem_we_c;

  logic [7:0]       byte_c;
  logic [AW-1:0]    addr_shift_c;
  logic             byte_end_c;
  logic [SIO_W-1:0] drive_c;

  // Incoming byte/address as they would look after this sample edge.
  assign byte_c       = quad_q ? {shift_q[3:0], sio_sync} : {shift_q[6:0], sio_sync[0]};
  assign addr_shift_c = quad_q ? AW'({addr_q, sio_sync}) : AW'({addr_q, sio_sync[0]});
  assign byte_end_c   = sck_rise_c & (bit_cnt_q == last_bit_idx(quad_q));
  assign drive_c      = quad_q ? (bit_cnt_q[0] ? rdata_q[3:0] : rdata_q[7:4])
                               : {2'b00, rdata_q[3'd7 - bit_cnt_q], 1'b0};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    is_read_d  = is_read_q;
    quad_d     = quad_q;
    sio_out_d  = sio_out_q;
    cmd_err_d  = 1'b0;
    busy_d     = ~cs_sync;
    mem_we_c   = 1'b0;

    if (cs_rise_c) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      sio_out_d  = '0;
    end else if (!cs_sync) begin
      if (sck_rise_c && state_q != ST_IDLE && state_q != ST_DRAIN) begin
        shift_d   = byte_c;
        bit_cnt_d = byte_end_c ? 3'd0 : bit_cnt_q + 3'd1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall_c) begin
            state_d    = ST_CMD;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            addr_d     = '0;
            sio_out_d  = '0;
          end
        end
        ST_CMD: begin
          if (byte_end_c) begin
            if (byte_c == CMD_READ || byte_c == CMD_WRITE) begin
              state_d   = ST_ADDR;
              is_read_d = (byte_c == CMD_READ);
            end else if (byte_c == CMD_EQIO && !quad_q) begin
              quad_d  = 1'b1;
              state_d = ST_DRAIN;
            end else if (byte_c == CMD_RSTIO && quad_q) begin
              quad_d  = 1'b0;
              state_d = ST_DRAIN;
            end else begin
              cmd_err_d = 1'b1;
              state_d   = ST_DRAIN;
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise_c) addr_d = addr_shift_c;
          if (byte_end_c) begin
            if (byte_cnt_q == CW'(ADDR_BYTES - 1)) begin
              byte_cnt_d = '0;
              // Dummy cycles only precede read data, and only on the quad link.
              if (is_read_q && quad_q && DUMMY_BYTES != 0) state_d = ST_DUMMY;
              else state_d = is_read_q ? ST_RDATA : ST_WDATA;
            end else begin
              byte_cnt_d = byte_cnt_q + CW'(1);
            end
          end
        end
        ST_DUMMY: begin
          if (byte_end_c) begin
            if (byte_cnt_q == CW'(DUMMY_BYTES - 1)) begin
              byte_cnt_d = '0;
              state_d    = ST_RDATA;
            end else begin
              byte_cnt_d = byte_cnt_q + CW'(1);
            end
          end
        end
        ST_RDATA: begin
          if (sck_fall_c) sio_out_d = drive_c;
          if (byte_end_c) addr_d = addr_q + AW'(1);
        end
        ST_WDATA: begin
          if (byte_end_c) begin
            mem_we_c = 1'b1;
            addr_d   = addr_q + AW'(1);
          end
        end
        ST_DRAIN: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end

    sio_oe_d = (state_d == ST_RDATA) ? (quad_q ? 4'b1111 : 4'b0010) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      is_read_q  <= 1'b0;
      quad_q     <= 1'b0;
      sio_out_q  <= '0;
      sio_oe_q   <= '0;
      cmd_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      is_read_q  <= is_read_d;
      quad_q     <= quad_d;
      sio_out_q  <= sio_out_d;
      sio_oe_q   <= sio_oe_d;
      cmd_err_q  <= cmd_err_d;
      busy_q     <= busy_d;
    end
  end

  // Single-port byte array; the read register continuously prefetches mem[addr_q].
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) mem[addr_q] <= byte_c;
    rdata_q <= mem[addr_q];
  end

`ifdef SPI_SRAM_TARGET_BACKDOOR_EN
  logic [7:0] bd_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) bd_rdata_q <= '0;
    else        bd_rdata_q <= mem[bd_addr];
  end

  assign bd_rdata = bd_rdata_q;
`endif

  assign sio_out   = sio_out_q;
  assign sio_oe    = sio_oe_q;
  assign quad_mode = quad_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;

endmodule
